pulse_train_encoder: RTL and testbench
======================================

// Module: pulse_train_encoder
// PURPOSE
//  Upstream stage of counter_pulse. Turns an accepted integer value into a
//  pulse train on one line, using complement unary coding. A downstream
//  counter that starts at MAX_VALUE and decrements once per high cycle
//  settles at exactly the accepted value.
//  Input side is a valid/ready handshake; one frame is in flight at a time.
// PARAMETERS
//  MAX_VALUE   8  largest encodable value; must match the downstream counter; >=1
//  GAP_CYCLES  1  low cycles after each burst, before the next frame; >=1
// PORTS
//  clock        in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high
//  in_valid     in   1   in_value is presented
//  in_ready     out  1   encoder can accept a value this cycle
//  in_value     in   CW  value to encode, CW = $clog2(MAX_VALUE+1)
//  pulse_line   out  1   encoded pulse train (registered)
//  busy         out  1   a frame is in progress (PULSE or GAP)
//  frame_done   out  1   one-cycle strobe on the last GAP cycle of a frame
// BEHAVIOUR
//  - Reset (async, active-high):
//    - state=IDLE
//    - pulse_line=0, busy=0, frame_done=0, in_ready=1
//    - all counters cleared
//    - a frame in flight is dropped; nothing is replayed
//  - Handshake:
//    - in_ready = (state==IDLE); combinational from state only
//    - accept occurs on an edge where in_valid && in_ready
//    - in_value is ignored whenever no accept occurs
//  - Arithmetic:
//    - v = min(in_value, MAX_VALUE); out-of-range codes saturate
//    - H = MAX_VALUE - v; H is held in a CW-bit down-counter
//  - FSM:
//    - IDLE: on accept, go to PULSE if H>0, else go to GAP
//    - PULSE: pulse_line=1 for exactly H consecutive cycles; the counter
//      decrements once per edge; when it reaches 1, go to GAP
//    - GAP: pulse_line=0 for exactly GAP_CYCLES cycles; frame_done=1 on the
//      last of them; then go to IDLE
//  - Latency:
//    - accept at edge E0 -> first high cycle starts at E0 (registered output)
//    - total frame length = H + GAP_CYCLES cycles; in_ready returns the cycle
//      after frame_done
//    - back-to-back throughput: one frame per H + GAP_CYCLES + 1 cycles
//  - Boundaries:
//    - v=MAX_VALUE gives H=0: no high cycles; frame is GAP only; frame_done
//      still fires
//    - v=0 gives H=MAX_VALUE high cycles
//    - pulse_line never glitches and is 0 outside PULSE
//    - busy = (state!=IDLE)
//    - in_valid changing mid-frame has no effect
//  - Reset mid-PULSE: pulse_line drops at once (async); no frame_done for the
//    aborted frame.
// TESTING
//  T1 MAX=8, GAP=1, in_value=3 -> 5 high cycles, 1 low cycle with
//     frame_done=1, in_ready=1 on the next cycle; a downstream counter_pulse
//     reads 3.
//  T2 in_value=0 -> 8 high cycles; in_value=8 -> 0 high cycles, frame_done
//     1 cycle after accept.
//  T3 in_value=12 (CW=4) -> saturates to 8 -> 0 high cycles; same timing as
//     in_value=8.
//  T4 in_valid held high with 2 then 6 -> frames of 6 and 2 high cycles,
//     separated by gap + IDLE cycle; second value is not accepted while busy.
//  T5 GAP=3, in_value=5 -> 3 high, 3 low; frame_done only on the 3rd low cycle.
//  T6 reset asserted on the 2nd high cycle of a value-1 frame -> pulse_line=0
//     at once, in_ready=1 after release, no frame_done.

Source files
------------

// File: rtl/pulse_train_encoder.sv
// pulse_train_encoder
//   Converts an accepted integer into a complement-unary pulse train on one line.
//   For an accepted value v (saturated to MAX_VALUE) the line is high for
//   MAX_VALUE - v consecutive cycles, then low for GAP_CYCLES cycles. A
//   downstream counter starting at MAX_VALUE and decrementing per high cycle
//   therefore settles at v. One frame is in flight at a time.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   in_valid    in   in_value is presented
//   in_ready    out  encoder is idle and can accept a value this cycle
//   in_value    in   value to encode, CW = $clog2(MAX_VALUE+1) bits
//   pulse_line  out  encoded pulse train (registered)
//   busy        out  a frame is in progress (pulse or gap phase)
//   frame_done  out  one-cycle strobe on the last gap cycle of a frame
module pulse_train_encoder #(
  parameter int unsigned MAX_VALUE  = 8,
  parameter int unsigned GAP_CYCLES = 1,
  localparam int unsigned CW = $clog2(MAX_VALUE + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_value,
  output logic          pulse_line,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] MaxV    = CW'(MAX_VALUE);
  localparam logic [GW-1:0] GapLast = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StGap
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] sat_value;
  logic [CW-1:0] high_count;

  // Out-of-range codes saturate so the downstream counter never underflows.
  assign sat_value  = (in_value > MaxV) ? MaxV : in_value;
  assign high_count = MaxV - sat_value;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          gap_d = '0;
          if (high_count != '0) begin
            state_d = StPulse;
            cnt_d   = high_count;
          end else begin
            // Zero high cycles: the frame is the gap alone.
            state_d = StGap;
          end
        end
      end
      StPulse: begin
        if (cnt_q == CW'(1)) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          frame_done = 1'b1;
          state_d    = StIdle;
          gap_d      = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        gap_d   = '0;
      end
    endcase
    // Derived from next state so the line is a clean flop output, high on the
    // cycle right after the accepting edge.
    pulse_d = (state_d == StPulse);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gap_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign pulse_line = pulse_q;

endmodule

// File: tb/tb_pulse_train_encoder.sv
module tb_pulse_train_encoder;

  localparam int unsigned Max = 8;
  localparam int unsigned Cw  = 4;

  typedef struct {
    int inst;
    int hi;
    int gap;
    int v;
  } frame_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          iv   [2];
  logic [Cw-1:0] ival [2];
  logic          ir   [2];
  logic          pl   [2];
  logic          bz   [2];
  logic          fd   [2];

  int     n_cmp = 0;
  int     n_bad = 0;
  frame_t sb[$];
  int     hi_cnt[2];
  int     lo_cnt[2];

  always #5 clock = ~clock;

  pulse_train_encoder #(.MAX_VALUE(Max), .GAP_CYCLES(1)) dut_g1 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (iv[0]),
    .in_ready  (ir[0]),
    .in_value  (ival[0]),
    .pulse_line(pl[0]),
    .busy      (bz[0]),
    .frame_done(fd[0])
  );

  pulse_train_encoder #(.MAX_VALUE(Max), .GAP_CYCLES(3)) dut_g3 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (iv[1]),
    .in_ready  (ir[1]),
    .in_value  (ival[1]),
    .pulse_line(pl[1]),
    .busy      (bz[1]),
    .frame_done(fd[1])
  );

  task automatic fail(input string tag, input int obs, input int exp);
    n_bad++;
    $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Output monitor: measures each frame and retires it against the scoreboard.
  initial begin
    frame_t e;
    hi_cnt[0] = 0; hi_cnt[1] = 0;
    lo_cnt[0] = 0; lo_cnt[1] = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hi_cnt[0] = 0; hi_cnt[1] = 0;
        lo_cnt[0] = 0; lo_cnt[1] = 0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (pl[k]) begin
            n_cmp++;
            if (bz[k] !== 1'b1) fail("pulse_outside_frame", bz[k], 1);
            n_cmp++;
            if (lo_cnt[k] !== 0) fail("pulse_after_gap", lo_cnt[k], 0);
            hi_cnt[k]++;
          end else if (bz[k]) begin
            lo_cnt[k]++;
          end
          if (fd[k]) begin
            n_cmp++;
            if (sb.size() == 0) fail("frame_done_expected", sb.size(), 1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              n_cmp++;
              if (k !== e.inst) fail("sb_instance", k, e.inst);
              n_cmp++;
              if (hi_cnt[k] !== e.hi) fail("sb_high_cycles", hi_cnt[k], e.hi);
              n_cmp++;
              if (lo_cnt[k] !== e.gap) fail("sb_gap_cycles", lo_cnt[k], e.gap);
              n_cmp++;
              if ((int'(Max) - hi_cnt[k]) !== e.v)
                fail("downstream_count", int'(Max) - hi_cnt[k], e.v);
            end
            hi_cnt[k] = 0;
            lo_cnt[k] = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int k, input int val, input int hi);
    frame_t f;
    f.inst = k;
    f.hi   = hi;
    f.gap  = (k == 0) ? 1 : 3;
    f.v    = (val > int'(Max)) ? int'(Max) : val;
    sb.push_back(f);
  endtask

  task automatic wait_idle(input string tag, input int k, input int exp_len);
    int n = 0;
    while (!ir[k] && n < 100) begin
      step();
      n++;
    end
    n_cmp++;
    if (n !== exp_len) fail(tag, n, exp_len);
  endtask

  // One complete frame: present, accept on the next edge, wait for idle.
  task automatic send(input int k, input int val, input int hi);
    int gap = (k == 0) ? 1 : 3;
    n_cmp++;
    if (ir[k] !== 1'b1) fail("ready_before_accept", ir[k], 1);
    iv[k]   = 1'b1;
    ival[k] = Cw'(val);
    push(k, val, hi);
    step();
    iv[k]   = 1'b0;
    ival[k] = Cw'($urandom_range(15, 0));
    n_cmp++;
    if (bz[k] !== 1'b1) fail("busy_after_accept", bz[k], 1);
    n_cmp++;
    if (ir[k] !== 1'b0) fail("ready_after_accept", ir[k], 0);
    n_cmp++;
    if (pl[k] !== (hi > 0)) fail("pulse_after_accept", pl[k], (hi > 0));
    wait_idle("frame_length", k, hi + gap);
  endtask

  initial begin
    bit seen_done;
    reset   = 1'b1;
    iv[0]   = 1'b0; iv[1]   = 1'b0;
    ival[0] = '0;   ival[1] = '0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (ir[k] !== 1'b1) fail("reset_ready", ir[k], 1);
      n_cmp++;
      if (bz[k] !== 1'b0) fail("reset_busy", bz[k], 0);
      n_cmp++;
      if (pl[k] !== 1'b0) fail("reset_pulse", pl[k], 0);
      n_cmp++;
      if (fd[k] !== 1'b0) fail("reset_done", fd[k], 0);
    end
    @(posedge clock);
    #3 reset = 1'b0;
    step();

    // Idle with a value but no valid: nothing starts.
    ival[0] = 4'd3;
    step();
    n_cmp++;
    if (bz[0] !== 1'b0) fail("no_accept_without_valid", bz[0], 0);

    // T1..T3
    send(0, 3, 5);
    send(0, 0, 8);
    send(0, 8, 0);
    send(0, 12, 0);
    send(0, 7, 1);

    // T4: valid held high across two frames.
    iv[0]   = 1'b1;
    ival[0] = 4'd2;
    push(0, 2, 6);
    step();
    ival[0] = 4'd6;
    push(0, 6, 2);
    n_cmp++;
    if (bz[0] !== 1'b1) fail("t4_first_busy", bz[0], 1);
    wait_idle("t4_first_len", 0, 7);
    step();
    iv[0] = 1'b0;
    n_cmp++;
    if (bz[0] !== 1'b1) fail("t4_second_busy", bz[0], 1);
    n_cmp++;
    if (pl[0] !== 1'b1) fail("t4_second_pulse", pl[0], 1);
    wait_idle("t4_second_len", 0, 3);

    // T5: three-cycle gap.
    send(1, 5, 3);
    send(1, 8, 0);

    // T6: reset during the second high cycle of a value-1 frame.
    iv[0]   = 1'b1;
    ival[0] = 4'd1;
    step();
    iv[0] = 1'b0;
    step();
    n_cmp++;
    if (pl[0] !== 1'b1) fail("t6_pulse_before_reset", pl[0], 1);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (pl[0] !== 1'b0) fail("t6_pulse_async_drop", pl[0], 0);
    n_cmp++;
    if (bz[0] !== 1'b0) fail("t6_busy_in_reset", bz[0], 0);
    n_cmp++;
    if (ir[0] !== 1'b1) fail("t6_ready_in_reset", ir[0], 1);
    @(posedge clock);
    #3 reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (fd[0]) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0) fail("t6_no_frame_done", seen_done, 0);
    n_cmp++;
    if (ir[0] !== 1'b1) fail("t6_ready_after_release", ir[0], 1);
    send(0, 4, 4);

    step();
    n_cmp++;
    if (sb.size() !== 0) fail("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
